// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter: FSM states, port index and command record.
// The round-robin tie-break is enabled by defining DMEM_ARB_RR_EN (see dmem_arb_pick).
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef logic port_idx_t;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the arbiter.
// Define DMEM_ARB_RR_EN for round-robin ties; otherwise port 0 has fixed priority.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic      p0_req,
    input  logic      p1_req,
    input  port_idx_t last_grant,
    output logic      any_req,
    output port_idx_t winner
);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        any_req = p0_req | p1_req;
        if (p0_req && p1_req) begin
            winner = ~last_grant;
        end else begin
            winner = p1_req & ~p0_req;
        end
    end
`else
    // Fixed priority never looks at the grant history; port 1 can starve under steady port 0 traffic.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        any_req = p0_req | p1_req;
        winner  = ~p0_req;
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter serialising core and DMA/debug accesses onto one 64-bit data memory.
// Tie-break policy selected by DMEM_ARB_RR_EN (round-robin when defined, fixed priority otherwise).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  count;
    port_idx_t         last_grant;
    port_idx_t         winner;
    logic              any_req;
    logic              grant;
    logic              finish;
    logic [DATA_W-1:0] ret_data;

    dmem_arb_pick u_pick (
        .p0_req     (p0_req),
        .p1_req     (p1_req),
        .last_grant (last_grant),
        .any_req    (any_req),
        .winner     (winner)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A ready in the last allowed cycle still counts as success, so it takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        finish    = 1'b0;
        ret_data  = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready || count == CNT_LAST) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (mem_ready && !mem_we) begin
            ret_data = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            p0_done    <= 1'b0;
            p0_err     <= 1'b0;
            p0_rdata   <= '0;
            p1_done    <= 1'b0;
            p1_err     <= 1'b0;
            p1_rdata   <= '0;
            busy       <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            count      <= '0;
        end else begin
            p0_done <= 1'b0;
            p0_err  <= 1'b0;
            p1_done <= 1'b0;
            p1_err  <= 1'b0;
            if (grant) begin
                mem_req    <= 1'b1;
                mem_we     <= winner ? p1_we    : p0_we;
                mem_addr   <= winner ? p1_addr  : p0_addr;
                mem_wdata  <= winner ? p1_wdata : p0_wdata;
                owner      <= winner;
                last_grant <= winner;
                count      <= '0;
                busy       <= 1'b1;
            end else if (state == ACCESS) begin
                if (finish) begin
                    mem_req <= 1'b0;
                    if (owner) begin
                        p1_done  <= 1'b1;
                        p1_err   <= ~mem_ready;
                        p1_rdata <= ret_data;
                    end else begin
                        p0_done  <= 1'b1;
                        p0_err   <= ~mem_ready;
                        p0_rdata <= ret_data;
                    end
                end else if (count != {CNT_W{1'b1}}) begin
                    count <= count + 1'b1;
                end
            end else if (state == DONE) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-schedule model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  we = '0;
    logic [9:0]  addr [2];
    logic [63:0] wdata [2];
    logic        p0_done, p0_err, p1_done, p1_err;
    logic [63:0] p0_rdata, p1_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic        busy, owner;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: the current transaction is described by its grant edge and planned ready latency
    int          edge_n = 0;
    int          next_free = 0;
    int          busy_clear = -1;
    bit          m_active = 0;
    bit          m_last = 1;
    bit          started = 0;
    int          g_edge = 0;
    int          r_lat = 0;
    int          d_edge = 0;
    bit          tx_port = 0;
    cmd_t        tx_cmd = '0;
    logic [63:0] tx_data = '0;
    int          forced_r = -1;
    logic [63:0] forced_data = '0;
    bit          auto_mode = 0;

    logic        e_mem_req = 0;
    cmd_t        e_cmd = '0;
    logic        e_busy = 0;
    logic        e_owner = 0;
    logic [1:0]  e_done = '0;
    logic [1:0]  e_err = '0;
    logic [1:0]  chk_rdata = '0;
    logic [63:0] e_rdata [2];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(10), .DATA_W(64), .TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (req[0]),
        .p0_we     (we[0]),
        .p0_addr   (addr[0]),
        .p0_wdata  (wdata[0]),
        .p0_done   (p0_done),
        .p0_rdata  (p0_rdata),
        .p0_err    (p0_err),
        .p1_req    (req[1]),
        .p1_we     (we[1]),
        .p1_addr   (addr[1]),
        .p1_wdata  (wdata[1]),
        .p1_done   (p1_done),
        .p1_rdata  (p1_rdata),
        .p1_err    (p1_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .owner     (owner)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h, expected %h at edge %0d", name, act, exp, edge_n);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: predicts post-edge outputs from the request rules and the planned ready latency
    always @(posedge clk) begin
        edge_n++;
        if (!rst) begin
            m_active   = 0;
            m_last     = 1;
            next_free  = edge_n + 1;
            busy_clear = -1;
            e_mem_req  = 0;
            e_cmd      = '0;
            e_busy     = 0;
            e_owner    = 0;
            e_done     = '0;
            e_err      = '0;
            e_rdata[0] = '0;
            e_rdata[1] = '0;
            chk_rdata  = 2'b11;
        end else begin
            e_done    = '0;
            e_err     = '0;
            chk_rdata = '0;
            if (m_active && edge_n == d_edge) begin
                e_mem_req          = 0;
                e_done[tx_port]    = 1'b1;
                e_err[tx_port]     = (r_lat >= T);
                e_rdata[tx_port]   = (r_lat >= T || tx_cmd.we) ? 64'd0 : tx_data;
                chk_rdata[tx_port] = 1'b1;
                m_active           = 0;
                next_free          = edge_n + 2;
                busy_clear         = edge_n + 1;
            end
            if (!m_active && edge_n == busy_clear) e_busy = 0;
            if (!m_active && edge_n >= next_free && (req[0] || req[1])) begin
`ifdef DMEM_ARB_RR_EN
                tx_port = (req[0] && req[1]) ? !m_last : req[1];
`else
                tx_port = !req[0];
`endif
                tx_cmd.we    = we[tx_port];
                tx_cmd.addr  = addr[tx_port];
                tx_cmd.wdata = wdata[tx_port];
                if (forced_r >= 0) begin
                    r_lat   = forced_r;
                    tx_data = forced_data;
                end else begin
                    r_lat   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(T - 2, T + 3))
                                                          : int'($urandom_range(0, 3));
                    tx_data = {$urandom, $urandom};
                end
                g_edge    = edge_n;
                d_edge    = edge_n + ((r_lat < T) ? r_lat : T - 1) + 1;
                e_mem_req = 1;
                e_cmd     = tx_cmd;
                e_owner   = tx_port;
                e_busy    = 1;
                m_last    = tx_port;
                m_active  = 1;
            end
        end
        started = 1;
    end

    // Every-cycle comparison of all outputs against the model
    always @(posedge clk) begin
        #2;
        if (started) begin
            checkOutput("mem_req", mem_req, e_mem_req);
            checkOutput("mem_we", mem_we, e_cmd.we);
            checkOutput("mem_addr", mem_addr, e_cmd.addr);
            checkOutput("mem_wdata", mem_wdata, e_cmd.wdata);
            checkOutput("busy", busy, e_busy);
            checkOutput("owner", owner, e_owner);
            checkOutput("p0_done", p0_done, e_done[0]);
            checkOutput("p1_done", p1_done, e_done[1]);
            checkOutput("p0_err", p0_err, e_err[0]);
            checkOutput("p1_err", p1_err, e_err[1]);
            if (chk_rdata[0]) checkOutput("p0_rdata", p0_rdata, e_rdata[0]);
            if (chk_rdata[1]) checkOutput("p1_rdata", p1_rdata, e_rdata[1]);
        end
    end

    // One negedge of stimulus: memory responder always, random requesters and resets in auto mode
    task automatic applyStimulus();
        @(negedge clk);
        mem_ready = m_active && (edge_n - g_edge == r_lat);
        mem_rdata = mem_ready ? tx_data : {$urandom, $urandom};
        if (auto_mode) begin
            rst = ($urandom_range(0, 79) != 0);
            for (int p = 0; p < 2; p++) begin
                if (req[p] && e_done[p]) begin
                    req[p] = 1'b0;
                end else if (!req[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req[p]   = 1'b1;
                        we[p]    = 1'($urandom_range(0, 1));
                        addr[p]  = 10'($urandom);
                        wdata[p] = {$urandom, $urandom};
                    end
                end else if (m_active && tx_port == p[0] && $urandom_range(0, 1) == 1) begin
                    we[p]    = 1'($urandom_range(0, 1));
                    addr[p]  = 10'($urandom);
                    wdata[p] = {$urandom, $urandom};
                end
            end
        end
    endtask

    initial begin
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        e_rdata[0] = '0; e_rdata[1] = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        rst = 1'b0;
        repeat (2) applyStimulus();
        rst = 1'b1;

        // Port 0 read with immediate ready
        applyStimulus();
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 10'd5; wdata[0] = '0;
        forced_r = 0; forced_data = 64'hDEAD_BEEF_0000_0001;
        @(posedge clk); #2;
        checkOutput("t1_mem_req", mem_req, 1);
        checkOutput("t1_mem_addr", mem_addr, 5);
        checkOutput("t1_mem_we", mem_we, 0);
        applyStimulus();
        @(posedge clk); #2;
        checkOutput("t1_p0_done", p0_done, 1);
        checkOutput("t1_p0_rdata", p0_rdata, 64'hDEAD_BEEF_0000_0001);
        checkOutput("t1_p0_err", p0_err, 0);
        checkOutput("t1_busy_done", busy, 1);
        applyStimulus();
        req[0] = 1'b0;
        @(posedge clk); #2;
        checkOutput("t1_busy_low", busy, 0);

        // Port 1 write to the top address, ready after 4 stall cycles, inputs scrambled mid-access
        applyStimulus();
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 10'd1023; wdata[1] = 64'h0123_4567_89AB_CDEF;
        forced_r = 4; forced_data = 64'hFFFF_0000_FFFF_0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            checkOutput("t2_mem_req", mem_req, 1);
            checkOutput("t2_mem_we", mem_we, 1);
            checkOutput("t2_mem_addr", mem_addr, 1023);
            checkOutput("t2_mem_wdata", mem_wdata, 64'h0123_4567_89AB_CDEF);
            checkOutput("t2_p1_done_early", p1_done, 0);
            applyStimulus();
            if (i == 1) begin
                addr[1] = 10'd7; wdata[1] = '0; we[1] = 1'b0;
            end
        end
        @(posedge clk); #2;
        checkOutput("t2_p1_done", p1_done, 1);
        checkOutput("t2_p1_rdata", p1_rdata, 0);
        checkOutput("t2_p1_err", p1_err, 0);
        checkOutput("t2_mem_req_off", mem_req, 0);
        applyStimulus();
        req[1] = 1'b0;
        @(posedge clk);

        // Both ports requesting continuously
        applyStimulus();
        req = 2'b11; we = 2'b00; addr[0] = 10'd16; addr[1] = 10'd32;
        forced_r = 0; forced_data = 64'h1111_2222_3333_4444;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
`ifdef DMEM_ARB_RR_EN
            checkOutput("t3_owner", owner, (k % 2 == 0) ? 64'd0 : 64'd1);
`else
            checkOutput("t3_owner", owner, 0);
`endif
            checkOutput("t3_mem_req", mem_req, 1);
            applyStimulus();
            @(posedge clk);
            applyStimulus();
            @(posedge clk);
            applyStimulus();
        end
        req[0] = 1'b0;
        @(posedge clk); #2;
        checkOutput("t3_owner_p1", owner, 1);
        checkOutput("t3_mem_addr_p1", mem_addr, 32);
        applyStimulus();
        @(posedge clk);
        applyStimulus();
        req[1] = 1'b0;
        @(posedge clk);

        // Timeout with memory never ready; port 0 inputs change during the stall
        applyStimulus();
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 10'h2AA; wdata[0] = 64'h5555;
        forced_r = 100; forced_data = 64'hAAAA_AAAA_AAAA_AAAA;
        for (int i = 0; i < T; i++) begin
            @(posedge clk); #2;
            checkOutput("t4_mem_req", mem_req, 1);
            checkOutput("t4_mem_addr", mem_addr, 10'h2AA);
            checkOutput("t4_mem_wdata", mem_wdata, 64'h5555);
            applyStimulus();
            if (i == 2) begin
                addr[0] = 10'd3; wdata[0] = '0;
            end
        end
        @(posedge clk); #2;
        checkOutput("t4_p0_done", p0_done, 1);
        checkOutput("t4_p0_err", p0_err, 1);
        checkOutput("t4_p0_rdata", p0_rdata, 0);
        checkOutput("t4_mem_req_off", mem_req, 0);
        applyStimulus();
        req[0] = 1'b0;
        @(posedge clk); #2;
        checkOutput("t4_busy_low", busy, 0);

        // Reset during a stalled access, then a tie after release
        applyStimulus();
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 10'd12; wdata[0] = 64'h77;
        forced_r = 100;
        @(posedge clk); #2;
        checkOutput("t5_mem_req", mem_req, 1);
        applyStimulus();
        @(posedge clk);
        applyStimulus();
        rst = 1'b0;
        @(posedge clk); #2;
        checkOutput("t5_rst_mem_req", mem_req, 0);
        checkOutput("t5_rst_mem_we", mem_we, 0);
        checkOutput("t5_rst_mem_addr", mem_addr, 0);
        checkOutput("t5_rst_mem_wdata", mem_wdata, 0);
        checkOutput("t5_rst_busy", busy, 0);
        checkOutput("t5_rst_owner", owner, 0);
        checkOutput("t5_rst_p0_done", p0_done, 0);
        checkOutput("t5_rst_p0_err", p0_err, 0);
        applyStimulus();
        rst = 1'b1; req[1] = 1'b1; we[1] = 1'b0; addr[1] = 10'd99;
        forced_r = 0; forced_data = 64'hCAFE;
        @(posedge clk); #2;
        checkOutput("t5_first_owner", owner, 0);
        checkOutput("t5_first_addr", mem_addr, 12);
        checkOutput("t5_first_mem_req", mem_req, 1);

        // Randomized traffic with occasional resets
        forced_r  = -1;
        auto_mode = 1;
        repeat (1500) applyStimulus();
        auto_mode = 0;
        rst = 1'b1;
        @(posedge clk); #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter that shares the 64-bit data memory between the core load/store path (port 0) and a DMA/debug requester (port 1). It serialises accesses through a small FSM, holds the winner's command stable toward memory until the memory accepts it, and returns registered read data with a one-cycle done pulse. A programmable timeout bounds how long a stalled memory can hold an access.

Parameters:
ADDR_W, 10, word-address width (1024 x 64-bit words)
DATA_W, 64, data width
TIMEOUT_CYCLES, 255, maximum ACCESS cycles before the transaction is aborted with error; range 1..65535

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
p0_req  in  1  port 0 request; held until p0_done
p0_we  in  1  port 0 write enable
p0_addr  in  ADDR_W  port 0 word address
p0_wdata  in  DATA_W  port 0 write data
p0_done  out  1  one-cycle completion pulse
p0_rdata  out  DATA_W  read data, valid while p0_done=1
p0_err  out  1  timeout flag, valid while p0_done=1
p1_req, p1_we, p1_addr, p1_wdata, p1_done, p1_rdata, p1_err  same as port 0
mem_req  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ready  in  1  memory accepts or completes the access this cycle
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
busy  out  1  high in ACCESS and DONE
owner  out  1  index of the current or most recent grantee

Behaviour:
- Reset: rst is synchronous and active-low; the clock is clk. When rst=0 at a posedge, all outputs and state clear: FSM=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, pX_done=0, pX_rdata=0, pX_err=0, busy=0, owner=0, last-grant=1 (so port 0 wins the first tie), timeout counter=0.
- Reset mid-access: the access is abandoned and no done pulse is issued. Memory must tolerate mem_req dropping.
- All outputs are registered.
- IDLE: if either req=1, pick a winner, latch its we/addr/wdata into the mem_* registers, set mem_req=1, owner=winner, counter=0, and go to ACCESS.
- ACCESS:
  - If mem_ready=1: capture mem_rdata into the winner's pX_rdata (write: capture 0), clear mem_req, set pX_done=1 and pX_err=0, go to DONE.
  - Else if counter==TIMEOUT_CYCLES-1: clear mem_req, set pX_done=1 and pX_err=1, pX_rdata=0, go to DONE.
  - Else increment counter.
- DONE: pX_done and pX_err clear next cycle; state returns to IDLE. The requester sees done and must deassert req by the following cycle. IDLE ignores a req that was the subject of the previous DONE only by virtue of this rule; the arbiter does not mask it.
- Minimum latency: req seen in cycle N -> mem_req in N+1 -> with mem_ready=1 in N+1, done in N+2. Throughput is one access per 3 cycles.
- The losing requester waits and is served in the next IDLE. Command inputs are sampled only in IDLE; changes afterwards are ignored.
- last-grant updates on every IDLE->ACCESS transition.
- The counter saturates logic with a width of clog2(TIMEOUT_CYCLES+1). It is unused outside ACCESS.
- Addresses are passed unmodified; there is no wrap or bounds check.

Optional Feature:
DMEM_ARB_RR_EN:
- Defined: round-robin. On a tie, the port not equal to last-grant wins; a single requester always wins.
- Undefined: fixed priority. Port 0 always wins ties; last-grant is still tracked and owner is still driven. Port 1 can starve under continuous port 0 traffic (documented, not a bug).

Decomposition:
- Package dmem_arb_pkg: FSM state enum (IDLE, ACCESS, DONE), default ADDR_W/DATA_W constants, a port-index type, and a command struct {we, addr, wdata}.
- One sub-module, dmem_arb_pick: combinational winner select from {p0_req, p1_req, last_grant}, containing the DMEM_ARB_RR_EN ifdef. The FSM, counter and datapath registers stay in the top.

Test Plan:
- Port 0 read, mem_ready tied 1, data 64'hDEAD_BEEF_0000_0001 at addr 5 -> mem_req=1, mem_addr=5 at cycle 1; p0_done=1, p0_rdata=64'hDEAD_BEEF_0000_0001, p0_err=0 at cycle 2; busy low at cycle 3.
- Port 1 write, addr 1023, wdata 64'h0123_4567_89AB_CDEF, mem_ready delayed 4 cycles -> mem_we=1 and command stable for all 4 stall cycles; p1_done one cycle after mem_ready; p1_rdata=0.
- Both ports request continuously, with RR_EN -> grants alternate 0,1,0,1 (owner sequence). Without RR_EN -> owner stays 0 until p0_req drops.
- mem_ready held 0, TIMEOUT_CYCLES=8 -> mem_req high exactly 8 cycles, then pX_done=1 and pX_err=1 with rdata=0, then IDLE.
- rst=0 asserted during ACCESS stall -> next cycle all outputs 0, no done pulse; after release with both requesting, port 0 wins first.
- Port 0 command inputs changed during ACCESS -> mem_addr/mem_wdata unchanged from the IDLE-sampled values.
